// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width, bit-counter width and the master FSM states.
package spi_pkg;

  localparam int SPI_WIDTH = 8;
  localparam int BIT_CNT_W = $clog2(SPI_WIDTH);

  typedef logic [SPI_WIDTH-1:0] spi_byte_t;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    GAP
  } spi_state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period timer: strobes on the last clk cycle of each CLK_DIV-long phase.
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_phase_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_phase_end = i_en && (r_cnt == LAST);

  // Held at zero while disabled so every phase starts with a full CLK_DIV count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!i_en || o_phase_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 byte master with a one-entry pending buffer and a minimum SS-high gap.
// Optional frame counter output enabled by defining SPI_MASTER_FRAME_CNT_EN.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SPI_WIDTH-1:0] tx_data,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [SPI_WIDTH-1:0] rx_data,
  output logic                 SCK,
  output logic                 SS,
  output logic                 MOSI,
  input  logic                 MISO
`ifdef SPI_MASTER_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  spi_state_e             r_state;
  spi_state_e             w_next;
  spi_byte_t              r_tx_sr;
  spi_byte_t              r_rx_sr;
  spi_byte_t              r_rx_data;
  spi_byte_t              r_pend_data;
  logic                   r_pend_valid;
  logic                   r_done;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [7:0]             r_gap_cnt;

  logic                   w_sck_en;
  logic                   w_phase_end;
  logic                   w_accept;
  logic                   w_gap_end;
  logic                   w_frame_end;
  logic                   w_load;
  spi_byte_t              w_load_data;

  assign w_sck_en    = (r_state == LEAD) || (r_state == HIGH) || (r_state == LOW);
  assign w_accept    = start && !r_pend_valid;
  assign w_gap_end   = (r_state == GAP) && (r_gap_cnt == 8'(GAP_CYC - 1));
  assign w_frame_end = (r_state == LOW) && w_phase_end && (r_bit_cnt == '1);
  assign w_load      = ((r_state == IDLE) && (r_pend_valid || w_accept)) ||
                       (w_gap_end && r_pend_valid);
  assign w_load_data = r_pend_valid ? r_pend_data : tx_data;

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_sck_en),
    .o_phase_end (w_phase_end)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: w_next gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (r_pend_valid || w_accept) w_next = LEAD;
      LEAD: if (w_phase_end) w_next = HIGH;
      HIGH: if (w_phase_end) w_next = LOW;
      LOW:  if (w_phase_end) w_next = (r_bit_cnt == '1) ? GAP : HIGH;
      GAP:  if (w_gap_end) w_next = r_pend_valid ? LEAD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    SS    = !w_sck_en;
    SCK   = (r_state == HIGH);
    MOSI  = w_sck_en ? r_tx_sr[SPI_WIDTH-1] : 1'b0;
    busy  = (r_state != IDLE);
    ready = !r_pend_valid;
    done  = r_done;
    rx_data = r_rx_data;
  end

  // NOTE: the datapath registers, pending byte included, are reset so rx_data reads 00 and
  // no stale byte can be resent after an abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_sr      <= '0;
      r_rx_sr      <= '0;
      r_rx_data    <= '0;
      r_pend_data  <= '0;
      r_pend_valid <= 1'b0;
      r_done       <= 1'b0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_done <= w_frame_end;

      if (w_load) begin
        r_tx_sr   <= w_load_data;
        r_bit_cnt <= '0;
      end else if ((r_state == HIGH) && w_phase_end) begin
        r_tx_sr <= {r_tx_sr[SPI_WIDTH-2:0], 1'b0};
      end else if ((r_state == LOW) && w_phase_end) begin
        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
      end

      if ((r_state == HIGH) && w_phase_end) begin
        r_rx_sr <= {r_rx_sr[SPI_WIDTH-2:0], MISO};
      end

      if (w_frame_end) begin
        r_rx_data <= r_rx_sr;
      end

      // An idle-state accept bypasses the buffer; anything accepted while busy waits here.
      if (w_accept && (r_state != IDLE)) begin
        r_pend_valid <= 1'b1;
        r_pend_data  <= tx_data;
      end else if (w_load && r_pend_valid) begin
        r_pend_valid <= 1'b0;
      end

      if (r_state == GAP) begin
        r_gap_cnt <= r_gap_cnt + 8'd1;
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

`ifdef SPI_MASTER_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
    end else if (w_frame_end && (r_frame_cnt != 16'hFFFF)) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (CLK_DIV/GAP_CYC 2/2 and 1/1), a mode-0 slave model and a frame scoreboard.
module tb_spi_master_ctrl;

  localparam int N = 2;

  function automatic int cd_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int gap_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  logic       clk = 1'b0;
  logic       rst      [N];
  logic       start    [N];
  logic [7:0] tx_data  [N];
  logic       ready    [N];
  logic       busy     [N];
  logic       done     [N];
  logic [7:0] rx_data  [N];
  logic       sck      [N];
  logic       ss       [N];
  logic       mosi     [N];
  logic       miso     [N];
`ifdef SPI_MASTER_FRAME_CNT_EN
  logic [15:0] frame_cnt [N];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_master_ctrl #(
      .CLK_DIV ((g == 0) ? 2 : 1),
      .GAP_CYC ((g == 0) ? 2 : 1)
    ) u_dut (
      .clk     (clk),
      .rst     (rst[g]),
      .start   (start[g]),
      .tx_data (tx_data[g]),
      .ready   (ready[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .rx_data (rx_data[g]),
      .SCK     (sck[g]),
      .SS      (ss[g]),
      .MOSI    (mosi[g]),
      .MISO    (miso[g])
`ifdef SPI_MASTER_FRAME_CNT_EN
      ,
      .frame_cnt (frame_cnt[g])
`endif
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: bytes the master must shift out, and bytes the slave will return, in order.
  logic [7:0] exp_q [$];
  logic [7:0] slv_q [$];

  logic       p_ss     [N];
  logic       p_sck    [N];
  logic       p_mosi   [N];
  logic [7:0] slv_sh   [N];
  logic [7:0] slv_out  [N];
  logic [7:0] cur_slv  [N];
  int         low_cnt  [N];
  int         high_cnt [N];
  int         last_gap [N];
  int         rise_cnt [N];
  int         rise_cyc [N];
  int         dones    [N];
  int         cyc = 0;

  initial begin
    for (int k = 0; k < N; k++) begin
      dones[k]    = 0;
      last_gap[k] = 0;
      cur_slv[k]  = 8'h00;
    end
  end

  // Mode-0 slave plus frame monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (!rst[k]) begin
        p_ss[k]     = 1'b1;
        p_sck[k]    = 1'b0;
        p_mosi[k]   = 1'b0;
        miso[k]     = 1'b0;
        low_cnt[k]  = 0;
        high_cnt[k] = 0;
        rise_cnt[k] = 0;
      end else begin
        check("done_vs_ss_rise", done[k], ss[k] && !p_ss[k]);
        if (ss[k] && !p_ss[k]) begin
          check("ss_low_len", low_cnt[k], 17 * cd_of(k));
          check("bits_in_frame", rise_cnt[k], 8);
          if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
          else check("mosi_byte", slv_out[k], exp_q.pop_front());
          check("rx_data", rx_data[k], cur_slv[k]);
          dones[k]++;
          high_cnt[k] = 1;
        end else if (ss[k]) begin
          high_cnt[k]++;
        end
        if (!ss[k] && p_ss[k]) begin
          last_gap[k] = high_cnt[k];
          low_cnt[k]  = 1;
          rise_cnt[k] = 0;
          cur_slv[k]  = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
          slv_sh[k]   = cur_slv[k];
          miso[k]     = slv_sh[k][7];
          slv_out[k]  = 8'h00;
        end else if (!ss[k]) begin
          low_cnt[k]++;
        end
        if (sck[k] && !p_sck[k]) begin
          if (rise_cnt[k] > 0) check("sck_period", cyc - rise_cyc[k], 2 * cd_of(k));
          rise_cyc[k] = cyc;
          rise_cnt[k]++;
          slv_out[k] = {slv_out[k][6:0], mosi[k]};
        end
        if (!sck[k] && p_sck[k]) begin
          slv_sh[k] = {slv_sh[k][6:0], 1'b0};
          miso[k]   = slv_sh[k][7];
        end
        if ((sck[k] && p_sck[k] && (mosi[k] != p_mosi[k])) || (ss[k] && (sck[k] || mosi[k])))
          check("mode0_pins", 1, 0);
        p_ss[k]   = ss[k];
        p_sck[k]  = sck[k];
        p_mosi[k] = mosi[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int k, input logic [7:0] b, input logic [7:0] s);
    int t = 0;
    while (!ready[k] && t < 1000) begin
      tick();
      t++;
    end
    check("ready_wait", ready[k], 1);
    start[k]   = 1'b1;
    tx_data[k] = b;
    exp_q.push_back(b);
    slv_q.push_back(s);
    tick();
    start[k]   = 1'b0;
    tx_data[k] = 8'($urandom);
  endtask

  task automatic wait_idle(input int k);
    int t = 0;
    while (busy[k] && t < 5000) begin
      tick();
      t++;
    end
    check("idle_timeout", busy[k], 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset(input int k);
    rst[k] = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    slv_q.delete();
    rst[k] = 1'b1;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [7:0] s;
    int         t;
    int         d0;

    for (int k = 0; k < N; k++) begin
      rst[k]     = 1'b0;
      start[k]   = 1'b0;
      tx_data[k] = 8'h00;
    end
    repeat (3) tick();
    check("rst_ss", ss[0], 1);
    check("rst_sck", sck[0], 0);
    check("rst_mosi", mosi[0], 0);
    check("rst_done", done[0], 0);
    check("rst_ready", ready[0], 1);
    check("rst_busy", busy[0], 0);
    check("rst_rx", rx_data[0], 8'h00);
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    tick();

    // Single byte A5 against slave B1.
    send(0, 8'hA5, 8'hB1);
    check("busy_after_start", busy[0], 1);
    wait_idle(0);
    check("a5_rx", rx_data[0], 8'hB1);
    check("a5_dones", dones[0], 1);

    // Two queued frames plus one start that must be ignored.
    send(0, 8'h3C, 8'h1F);
    repeat (2) tick();
    send(0, 8'hF0, 8'hEA);
    check("ready_full", ready[0], 0);
    check("busy_full", busy[0], 1);
    start[0]   = 1'b1;
    tx_data[0] = 8'h77;
    tick();
    start[0] = 1'b0;
    wait_idle(0);
    check("b2b_gap", last_gap[0], gap_of(0));
    check("b2b_rx_last", rx_data[0], 8'hEA);
    check("b2b_dones", dones[0], 3);

    // Start in the same cycle as done.
    send(0, 8'h5A, 8'hC3);
    t = 0;
    while (!done[0] && t < 1000) begin
      tick();
      t++;
    end
    check("done_seen", done[0], 1);
    check("ready_at_done", ready[0], 1);
    start[0]   = 1'b1;
    tx_data[0] = 8'h96;
    exp_q.push_back(8'h96);
    slv_q.push_back(8'h3E);
    tick();
    start[0] = 1'b0;
    check("pending_at_done", ready[0], 0);
    wait_idle(0);
    check("done_coinc_gap", last_gap[0], gap_of(0));
    check("done_coinc_rx", rx_data[0], 8'h3E);
    check("done_coinc_dones", dones[0], 5);

    // Reset mid-frame after the fourth SCK rise, with a byte pending.
    send(0, 8'hA5, 8'h5C);
    send(0, 8'h3C, 8'h77);
    t = 0;
    while (rise_cnt[0] < 4 && t < 1000) begin
      tick();
      t++;
    end
    check("fourth_rise", rise_cnt[0], 4);
    d0 = dones[0];
    rst[0] = 1'b0;
    #1;
    check("abort_ss", ss[0], 1);
    check("abort_sck", sck[0], 0);
    check("abort_mosi", mosi[0], 0);
    check("abort_done", done[0], 0);
    check("abort_ready", ready[0], 1);
    check("abort_rx", rx_data[0], 8'h00);
    repeat (2) tick();
    exp_q.delete();
    slv_q.delete();
    rst[0] = 1'b1;
    repeat (12) tick();
    check("pend_discard_busy", busy[0], 0);
    check("pend_discard_ss", ss[0], 1);
    check("abort_no_done", dones[0], d0);
    send(0, 8'hF0, 8'hA3);
    wait_idle(0);
    check("post_reset_rx", rx_data[0], 8'hA3);

    // Fastest configuration.
    send(1, 8'hFF, 8'h6D);
    wait_idle(1);
    check("fast_rx", rx_data[1], 8'h6D);
    check("fast_dones", dones[1], 1);

    // Randomized frames, sometimes back-to-back.
    for (int i = 0; i < 12; i++) begin
      int k;
      k = i % N;
      b = 8'($urandom);
      s = 8'($urandom);
      send(k, b, s);
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(5, 0)) tick();
        s = 8'($urandom);
        send(k, 8'($urandom), s);
        check("rand_ready_full", ready[k], 0);
      end
      wait_idle(k);
      check("rand_rx", rx_data[k], s);
    end

`ifdef SPI_MASTER_FRAME_CNT_EN
    do_reset(1);
    check("cnt_reset", frame_cnt[1], 16'h0000);
    for (int i = 0; i < 3; i++) begin
      send(1, 8'($urandom), 8'($urandom));
      wait_idle(1);
    end
    check("cnt_three", frame_cnt[1], 16'd3);
    g_dut[1].u_dut.r_frame_cnt = 16'hFFFD;
    for (int i = 0; i < 3; i++) begin
      send(1, 8'($urandom), 8'($urandom));
      wait_idle(1);
    end
    check("cnt_saturate", frame_cnt[1], 16'hFFFF);
`else
    do_reset(1);
    send(1, 8'h81, 8'h18);
    wait_idle(1);
    check("final_rx", rx_data[1], 8'h18);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
